// File: rtl/obi_dma_copy.sv
// obi_dma_copy
//   Single-channel OBI initiator. It copies a block of 32-bit words from a
//   source range to a destination range, one word at a time. Each word is a
//   read followed by a write, and at most one transaction is outstanding.
//
//   Build option: define DMA_CHECKSUM_EN to add a running 32-bit sum of every
//   word read. When it is undefined, sum_o is tied to zero and no adder is
//   built.
//
//   Ports
//     clk_i, rst_ni        clock, asynchronous active-low reset
//     start_i              launch a copy; sampled only in IDLE
//     src_addr_i/dst_addr_i first source/destination byte address
//     len_i                number of words to copy
//     busy_o, done_o       copy in flight / one-cycle end pulse
//     err_o                misaligned start flag, sticky until next start
//     sum_o                checksum of words read (or 0)
//     dma_*                OBI manager port (req/gnt/addr/we/be/wdata/rvalid/rdata)
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   S_IDLE    | waiting for start_i
//   S_RD_REQ  | read request on the bus, waiting for grant
//   S_RD_WAIT | read granted, waiting for rvalid
//   S_WR_REQ  | write request on the bus, waiting for grant
//   S_WR_WAIT | write granted, waiting for rvalid
//   S_DONE    | one-cycle done pulse, then back to IDLE
module obi_dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      sum_o,
  output logic             dma_req_o,
  input  logic             dma_gnt_i,
  output logic [31:0]      dma_addr_o,
  output logic             dma_we_o,
  output logic [3:0]       dma_be_o,
  output logic [31:0]      dma_wdata_o,
  input  logic             dma_rvalid_i,
  input  logic [31:0]      dma_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_data;
  logic [LEN_W-1:0] r_cnt;
  logic             r_err;

  logic w_start_ok;
  logic w_misalign;
  logic w_rd_done;
  logic w_wr_done;

  assign w_start_ok = (r_state == S_IDLE) && start_i;
  assign w_misalign = (|src_addr_i[1:0]) || (|dst_addr_i[1:0]);
  assign w_rd_done  = (r_state == S_RD_WAIT) && dma_rvalid_i;
  assign w_wr_done  = (r_state == S_WR_WAIT) && dma_rvalid_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_misalign || (len_i == '0)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RD_REQ;
          end
        end
      end
      S_RD_REQ:  if (dma_gnt_i)    w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (dma_rvalid_i) w_state_nxt = S_WR_REQ;
      S_WR_REQ:  if (dma_gnt_i)    w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (dma_rvalid_i) begin
          // The count still holds the word being finished.
          w_state_nxt = (r_cnt == LEN_W'(1)) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from the state only. The bus fields are therefore frozen
  // for as long as a request waits for its grant, and they drop to zero
  // asynchronously on reset.
  always_comb begin
    dma_req_o   = 1'b0;
    dma_we_o    = 1'b0;
    dma_addr_o  = 32'h0;
    dma_wdata_o = 32'h0;
    dma_be_o    = 4'h0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_RD_REQ: begin
        dma_req_o  = 1'b1;
        dma_addr_o = r_src;
        dma_be_o   = 4'hF;
        busy_o     = 1'b1;
      end
      S_WR_REQ: begin
        dma_req_o   = 1'b1;
        dma_we_o    = 1'b1;
        dma_addr_o  = r_dst;
        dma_wdata_o = r_data;
        dma_be_o    = 4'hF;
        busy_o      = 1'b1;
      end
      S_RD_WAIT, S_WR_WAIT: busy_o = 1'b1;
      S_DONE:               done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: pointers, count, data register, error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src  <= 32'h0;
      r_dst  <= 32'h0;
      r_data <= 32'h0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_src <= src_addr_i;
        r_dst <= dst_addr_i;
        r_cnt <= len_i;
        r_err <= w_misalign;
      end
      if (w_rd_done) begin
        r_data <= dma_rdata_i;
        r_src  <= r_src + 32'd4;
      end
      if (w_wr_done) begin
        r_dst <= r_dst + 32'd4;
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  assign err_o = r_err;

`ifdef DMA_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sum <= 32'h0;
    end else if (w_start_ok) begin
      r_sum <= 32'h0;
    end else if (w_rd_done) begin
      r_sum <= r_sum + dma_rdata_i;
    end
  end

  assign sum_o = r_sum;
`else
  assign sum_o = 32'h0;
`endif

endmodule
